reg_read_scoreboard: RTL and testbench
======================================

# reg_read_scoreboard

Tracks which architectural registers have a write outstanding from an issued instruction, and stalls the decode-stage instruction when it reads one of them. It is the read side of the destination-register decode. It decodes the *source* registers of the instruction in decode and compares them against a 32-entry pending-write vector. Entries are set at issue and cleared at writeback. It sits between the decode stage and the hazard/stall logic, mainly covering long-latency multdiv results and load-use cases.

## Interface
Parameters:
- none

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising edge
- dec_valid  input  1  decode-stage instruction is valid
- dec_insn  input  32  decode-stage instruction
- issue_valid  input  1  an instruction leaves decode this cycle
- issue_insn  input  32  the issuing instruction
- wb_valid  input  1  a register write occurs this cycle
- wb_reg  input  5  register being written
- stall  output  1  decode must hold (combinational from state plus inputs)
- pending  output  32  pending-write vector; bit i set means r_i has an outstanding write
- stall_cycles  output  32  saturating count of cycles with stall=1

## Operation
- **Source decode of dec_insn.** The opcode is [31:27]; rd=[26:22], rs=[21:17], rt=[16:12].
  - 00000 (R-type): reads rs, rt.
  - 00101 (addi), 01000 (lw): reads rs.
  - 00111 (sw), 00010 (bne), 00110 (blt): reads rd, rs.
  - 00100 (jr): reads rd.
  - 10110 (bex): reads r30.
  - All other opcodes (j 00001, jal 00011, setx 10101, undefined): read nothing.
- **Destination decode of issue_insn.**
  - Opcode 00000, 00101 or 01000: destination is [26:22].
  - 00011: destination is r31.
  - 10101: destination is r30.
  - Otherwise: destination is r0 (no write).
- **Set.** When issue_valid=1 and the destination is nonzero, the pending bit for that destination is set on the next edge.
- **Clear.** When wb_valid=1 and wb_reg≠0, the pending bit for wb_reg is cleared on the next edge.
- **Set and clear on the same register in the same cycle:** set wins, because the newer write remains outstanding.
- **r0:** pending[0] is constant 0. Reads of r0 never stall, and writes to r0 are never tracked.
- **Stall.** stall = dec_valid AND (some decoded source s≠0 has pending[s]=1) AND NOT (wb_valid AND wb_reg==s). This write-through bypass means a source being written back this cycle does not stall.
- **Multiple sources:** stall if any one source qualifies. When rs==rt, that register is evaluated once.
- **Issue during stall:** issue_valid with stall=1 is a protocol violation and is not checked. The block still sets the bit if issue_valid=1.
- **stall_cycles:** increments by 1 on every edge where stall=1. It saturates at 0xFFFFFFFF and does not wrap.
- **Reset:** pending=0 and stall_cycles=0. Reset in the middle of an operation discards all outstanding entries; set and clear in the reset cycle are ignored.

## Timing
- Reset values: pending=32'h0, stall_cycles=32'h0. stall=0 while pending=0.
- Issue at cycle t: pending bit visible at t+1, so an instruction in decode at t+1 that reads it stalls.
- Writeback at cycle t: stall drops in cycle t (bypass); the pending bit reads 0 from t+1.
- stall has zero-cycle latency from dec_insn, dec_valid, wb_valid and wb_reg. It has one-cycle latency from issue.
- stall_cycles reflects the stall of cycle t at t+1.

## Test plan
- **Reset:** assert reset for 2 cycles with random inputs -> pending=0, stall_cycles=0, stall=0.
- **Mul stall and release:**
  - Issue R-type with rd=5 (mul), then hold dec_insn = R-type with rs=5, rt=2 and dec_valid=1 for 4 cycles -> stall=1 and stall_cycles increments 1..4.
  - Then pulse wb_valid, wb_reg=5 -> stall=0 in that cycle, and pending[5]=0 next cycle.
- **Write-destination and special registers:**
  - Issue setx -> pending[30]=1, and decode bex -> stall=1.
  - Issue jal -> pending[31]=1.
  - Decode jr with rd=31 -> stall=1.
  - Decode j -> stall=0.
- **Same-cycle set and clear:** pending[7]=1, then in one cycle issue addi rd=7 and wb_reg=7 -> pending[7] stays 1.
- **r0 and non-readers:**
  - Issue addi rd=0 -> pending unchanged.
  - Decode sw with rd=0, rs=0 -> stall=0.
  - Decode lw with rs=3 while only pending[4]=1 -> stall=0.
- **Saturation and reset mid-operation:**
  - Force stall_cycles near 0xFFFFFFFE (via long stall or backdoor) -> reaches 0xFFFFFFFF and holds.
  - Assert reset with pending=0x0000_00F0 -> next cycle pending=0 and stall=0.

Source files
------------

// File: rtl/reg_read_scoreboard.sv
// Pending-write scoreboard for the decode stage: tracks outstanding register writes and
// stalls a decoded instruction whose sources still have a write in flight.
module reg_read_scoreboard (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_dec_valid,
  input  logic [31:0] i_dec_insn,
  input  logic        i_issue_valid,
  input  logic [31:0] i_issue_insn,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_reg,
  output logic        o_stall,
  output logic [31:0] o_pending,
  output logic [31:0] o_stall_cycles
);

  localparam logic [4:0] OpRType = 5'b00000;
  localparam logic [4:0] OpJ     = 5'b00001;
  localparam logic [4:0] OpBne   = 5'b00010;
  localparam logic [4:0] OpJal   = 5'b00011;
  localparam logic [4:0] OpJr    = 5'b00100;
  localparam logic [4:0] OpAddi  = 5'b00101;
  localparam logic [4:0] OpBlt   = 5'b00110;
  localparam logic [4:0] OpSw    = 5'b00111;
  localparam logic [4:0] OpLw    = 5'b01000;
  localparam logic [4:0] OpSetx  = 5'b10101;
  localparam logic [4:0] OpBex   = 5'b10110;

  logic [31:0] r_pending;
  logic [31:0] r_stall_cycles;

  logic [4:0]  w_dec_op;
  logic [4:0]  w_dec_rd;
  logic [4:0]  w_dec_rs;
  logic [4:0]  w_dec_rt;
  logic [4:0]  w_iss_op;
  logic [4:0]  w_iss_dest;
  logic [31:0] w_read_mask;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;
  logic [31:0] w_hit;
  logic [31:0] w_pending_d;
  logic        w_stall;
  logic        w_unused;

  function automatic logic [31:0] onehot(input logic [4:0] idx);
    onehot = 32'h1 << idx;
  endfunction

  assign w_dec_op = i_dec_insn[31:27];
  assign w_dec_rd = i_dec_insn[26:22];
  assign w_dec_rs = i_dec_insn[21:17];
  assign w_dec_rt = i_dec_insn[16:12];
  assign w_iss_op = i_issue_insn[31:27];

  // Immediate / offset fields play no part in hazard tracking.
  assign w_unused = ^{i_dec_insn[11:0], i_issue_insn[21:0]};

  always_comb begin
    w_read_mask = '0;
    case (w_dec_op)
      OpRType:             w_read_mask = onehot(w_dec_rs) | onehot(w_dec_rt);
      OpAddi, OpLw:        w_read_mask = onehot(w_dec_rs);
      OpSw, OpBne, OpBlt:  w_read_mask = onehot(w_dec_rd) | onehot(w_dec_rs);
      OpJr:                w_read_mask = onehot(w_dec_rd);
      OpBex:               w_read_mask = onehot(5'd30);
      OpJ, OpJal, OpSetx:  w_read_mask = '0;
      default:             w_read_mask = '0;
    endcase
  end

  always_comb begin
    w_iss_dest = 5'd0;
    case (w_iss_op)
      OpRType, OpAddi, OpLw: w_iss_dest = i_issue_insn[26:22];
      OpJal:                 w_iss_dest = 5'd31;
      OpSetx:                w_iss_dest = 5'd30;
      default:               w_iss_dest = 5'd0;
    endcase
  end

  assign w_set_mask = i_issue_valid ? (onehot(w_iss_dest) & ~32'h1) : '0;
  assign w_clr_mask = i_wb_valid ? (onehot(i_wb_reg) & ~32'h1) : '0;

  // A source being written back this cycle is bypassed, so it never stalls.
  assign w_hit   = w_read_mask & r_pending & ~w_clr_mask & ~32'h1;
  assign w_stall = i_dec_valid & (|w_hit);

  // Set is applied after clear so a fresh issue outlives a same-register writeback.
  assign w_pending_d = ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'h1;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pending      <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_pending <= w_pending_d;
      if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign o_stall        = w_stall;
  assign o_pending      = r_pending;
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_reg_read_scoreboard.sv
// Directed scoreboard bench for reg_read_scoreboard: expectations are queued as stimulus is
// driven and popped against DUT outputs when they are sampled.
module tb_reg_read_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [31:0] dec_insn;
  logic        issue_valid;
  logic [31:0] issue_insn;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic        stall;
  logic [31:0] pending;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];

  reg_read_scoreboard dut (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_dec_valid    (dec_valid),
    .i_dec_insn     (dec_insn),
    .i_issue_valid  (issue_valid),
    .i_issue_insn   (issue_insn),
    .i_wb_valid     (wb_valid),
    .i_wb_reg       (wb_reg),
    .o_stall        (stall),
    .o_pending      (pending),
    .o_stall_cycles (stall_cycles)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] insn(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
    insn = {op, rd, rs, rt, 12'h0};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    sb_entry_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    sb_entry_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %h required an expectation", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [31:0] di, input logic iv,
                       input logic [31:0] ii, input logic wv, input logic [4:0] wr);
    dec_valid   = dv;
    dec_insn    = di;
    issue_valid = iv;
    issue_insn  = ii;
    wb_valid    = wv;
    wb_reg      = wr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_stall(input string tag, input logic exp);
    push(tag, {31'h0, exp});
    #1;
    pop_check({31'h0, stall});
  endtask

  task automatic check_regs(input string tag, input logic [31:0] exp_pend,
                            input logic [31:0] exp_cnt);
    push({tag, "_pending"}, exp_pend);
    push({tag, "_count"}, exp_cnt);
    pop_check(pending);
    pop_check(stall_cycles);
  endtask

  initial begin
    // Reset with random traffic on every input.
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom), 5'($urandom));
      tick();
    end
    check_regs("reset", 32'h0, 32'h0);
    reset = 1'b0;
    drive(1'b1, $urandom, 1'b0, 32'h0, 1'b0, 5'd0);
    check_stall("reset_stall", 1'b0);
    tick();

    // Mul to r5, then a dependent R-type held in decode.
    drive(1'b0, 32'h0, 1'b1, insn(5'b00000, 5'd5, 5'd1, 5'd2), 1'b0, 5'd0);
    tick();
    check_regs("mul_issue", 32'h0000_0020, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, insn(5'b00000, 5'd9, 5'd5, 5'd2), 1'b0, 32'h0, 1'b0, 5'd0);
      check_stall("mul_stall", 1'b1);
      tick();
      check_regs("mul_hold", 32'h0000_0020, 32'(i + 1));
    end
    drive(1'b1, insn(5'b00000, 5'd9, 5'd5, 5'd2), 1'b0, 32'h0, 1'b1, 5'd5);
    check_stall("wb_bypass", 1'b0);
    tick();
    check_regs("wb_clear", 32'h0, 32'd4);

    // setx -> r30; bex stalls on it while jal claims r31.
    drive(1'b0, 32'h0, 1'b1, insn(5'b10101, 5'd0, 5'd0, 5'd0), 1'b0, 5'd0);
    tick();
    check_regs("setx", 32'h4000_0000, 32'd4);
    drive(1'b1, insn(5'b10110, 5'd0, 5'd0, 5'd0), 1'b1, insn(5'b00011, 5'd0, 5'd0, 5'd0),
          1'b0, 5'd0);
    check_stall("bex_stall", 1'b1);
    tick();
    check_regs("jal", 32'hC000_0000, 32'd5);
    drive(1'b1, insn(5'b00100, 5'd31, 5'd0, 5'd0), 1'b0, 32'h0, 1'b0, 5'd0);
    check_stall("jr_stall", 1'b1);
    tick();
    drive(1'b1, insn(5'b00001, 5'd31, 5'd30, 5'd30), 1'b0, 32'h0, 1'b0, 5'd0);
    check_stall("j_nostall", 1'b0);
    tick();
    check_regs("after_j", 32'hC000_0000, 32'd6);

    // Same-cycle set and clear on r7: set wins.
    drive(1'b0, 32'h0, 1'b1, insn(5'b00101, 5'd7, 5'd1, 5'd0), 1'b0, 5'd0);
    tick();
    drive(1'b0, 32'h0, 1'b1, insn(5'b00101, 5'd7, 5'd1, 5'd0), 1'b1, 5'd7);
    tick();
    check_regs("set_wins", 32'hC000_0080, 32'd6);

    // Drain, then leave only r4 pending.
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd30);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd31);
    tick();
    drive(1'b0, 32'h0, 1'b1, insn(5'b01000, 5'd4, 5'd1, 5'd0), 1'b1, 5'd7);
    tick();
    check_regs("only_r4", 32'h0000_0010, 32'd6);

    // r0 is never tracked, and non-matching sources do not stall.
    drive(1'b0, 32'h0, 1'b1, insn(5'b00101, 5'd0, 5'd4, 5'd0), 1'b0, 5'd0);
    tick();
    check_regs("addi_r0", 32'h0000_0010, 32'd6);
    drive(1'b1, insn(5'b00111, 5'd0, 5'd0, 5'd4), 1'b0, 32'h0, 1'b0, 5'd0);
    check_stall("sw_r0", 1'b0);
    drive(1'b1, insn(5'b01000, 5'd4, 5'd3, 5'd4), 1'b0, 32'h0, 1'b0, 5'd0);
    check_stall("lw_r3", 1'b0);
    drive(1'b1, insn(5'b00101, 5'd1, 5'd4, 5'd0), 1'b0, 32'h0, 1'b0, 5'd0);
    check_stall("addi_r4", 1'b1);
    tick();
    check_regs("addi_r4", 32'h0000_0010, 32'd7);

    // Saturation: preload the counter just below the top and keep stalling.
    force dut.r_stall_cycles = 32'hFFFF_FFFD;
    #1;
    release dut.r_stall_cycles;
    check_stall("sat_stall", 1'b1);
    tick();
    check_regs("sat_fe", 32'h0000_0010, 32'hFFFF_FFFE);
    tick();
    check_regs("sat_ff", 32'h0000_0010, 32'hFFFF_FFFF);
    tick();
    check_regs("sat_hold", 32'h0000_0010, 32'hFFFF_FFFF);

    // Build pending = 0xF0, then reset mid-operation with conflicting set/clear.
    for (int r = 5; r < 8; r++) begin
      drive(1'b0, 32'h0, 1'b1, insn(5'b00000, 5'(r), 5'd1, 5'd2), 1'b0, 5'd0);
      tick();
    end
    check_regs("pend_f0", 32'h0000_00F0, 32'hFFFF_FFFF);
    reset = 1'b1;
    drive(1'b1, insn(5'b00101, 5'd1, 5'd4, 5'd0), 1'b1, insn(5'b00101, 5'd9, 5'd1, 5'd0),
          1'b1, 5'd4);
    tick();
    check_regs("mid_reset", 32'h0, 32'h0);
    reset = 1'b0;
    drive(1'b1, insn(5'b00101, 5'd1, 5'd4, 5'd0), 1'b0, 32'h0, 1'b0, 5'd0);
    check_stall("post_reset", 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
